// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
// strb_merge works on a wide word; callers zero-extend inputs and truncate the result.
package regfile_pkg;

  typedef enum logic {ST_INIT, ST_RUN} rf_state_e;

  localparam int RF_MAX_W = 256;

  typedef logic [RF_MAX_W-1:0]   rf_word_t;
  typedef logic [RF_MAX_W/8-1:0] rf_strb_t;

  function automatic rf_word_t strb_merge(rf_word_t old_w, rf_word_t new_w, rf_strb_t strb);
    rf_word_t r;
    r = old_w;
    for (int b = 0; b < RF_MAX_W/8; b++)
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: range check, zero-register, write bypass and registered output.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   word,
  input  logic                wr_fire,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic [DATA_W-1:0]   data,
  output logic                valid,
  output logic                oor
);

  logic              in_range;
  logic              is_zero;
  logic              bypass_hit;
  logic [DATA_W-1:0] nxt;

  assign in_range   = {1'b0, addr} < (ADDR_W+1)'(DEPTH);
  assign oor        = en && !in_range;
  assign is_zero    = (ZERO_REG0 != 0) && (addr == '0);
  assign bypass_hit = (BYPASS != 0) && wr_fire && (wr_addr == addr);

  always_comb begin
    nxt = word;
    if (!in_range || is_zero)
      nxt = '0;
    else if (bypass_hit)
      nxt = DATA_W'(strb_merge(rf_word_t'(word), rf_word_t'(wr_data), rf_strb_t'(wr_strb)));
  end

  // data holds its last value while the port is idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= en;
      if (en) data <= nxt;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Native register file: one byte-strobed write port, NUM_RD read ports, 1-cycle reads.
// A clear-all sweep zeroes the array after reset so the storage itself needs no reset.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_strb,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clear_req,
  output logic                     ready,
  output logic                     err
);

  rf_state_e         state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              wr_in_range;
  logic              wr_fire;
  logic              wr_oor;
  logic [NUM_RD-1:0] rd_oor;

  assign run         = (state == ST_RUN);
  assign wr_in_range = {1'b0, wr_addr} < (ADDR_W+1)'(DEPTH);
  assign wr_fire     = run && wr_en && wr_in_range && !((ZERO_REG0 != 0) && (wr_addr == '0));
  assign wr_oor      = run && wr_en && !wr_in_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= wr_oor || (|rd_oor);
      case (state)
        ST_INIT: begin
          if (cnt == ADDR_W'(DEPTH-1)) begin
            state <= ST_RUN;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Per-byte write enables keep the array in the shape RAM inference expects.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG0(ZERO_REG0),
      .BYPASS   (BYPASS)
    ) u_rd (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (run && rd_en[i]),
      .addr   (addr),
      .word   (mem[addr]),
      .wr_fire(wr_fire),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .wr_strb(wr_strb),
      .data   (rd_data[i*DATA_W +: DATA_W]),
      .valid  (rd_valid[i]),
      .oor    (rd_oor[i])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Two configurations share one stimulus stream: A = 32 deep, zero reg, bypass;
// B = 20 deep, no zero reg, no bypass. Each is compared to an array model every cycle.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        clear_req;

  logic [1:0][63:0] rdd;
  logic [1:0][1:0]  rdv;
  logic [1:0]       rdy;
  logic [1:0]       er;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG0(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0]),
    .clear_req(clear_req), .ready(rdy[0]), .err(er[0])
  );

  regfile_multiport #(.DATA_W(32), .DEPTH(20), .NUM_RD(2), .ZERO_REG0(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_strb(wr_strb), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1]),
    .clear_req(clear_req), .ready(rdy[1]), .err(er[1])
  );

  int          dep [2] = '{32, 20};
  bit          zr  [2] = '{1'b1, 1'b0};
  bit          byp [2] = '{1'b1, 1'b0};
  string       nm  [2] = '{"a", "b"};
  logic [31:0] mm  [2][32];
  int          left[2];
  logic [31:0] ed  [2][2];
  logic [1:0]  ev  [2];
  logic        ee  [2];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] s);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = dep[k];
      ev[k]   = '0;
      ee[k]   = 1'b0;
      for (int i = 0; i < 2; i++) ed[k][i] = '0;
      for (int a = 0; a < 32; a++) mm[k][a] = '0;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit run   = (left[k] == 0);
      bit lands = run && wr_en && (int'(wr_addr) < dep[k]) && !(zr[k] && wr_addr == 0);
      ee[k] = run && wr_en && (int'(wr_addr) >= dep[k]);
      for (int i = 0; i < 2; i++) begin
        ev[k][i] = run && rd_en[i];
        if (ev[k][i]) begin
          int a = int'(rd_addr[i*5 +: 5]);
          if (a >= dep[k]) begin
            ed[k][i] = '0;
            ee[k]    = 1'b1;
          end else if (zr[k] && a == 0)
            ed[k][i] = '0;
          else if (byp[k] && lands && int'(wr_addr) == a)
            ed[k][i] = merge(mm[k][a], wr_data, wr_strb);
          else
            ed[k][i] = mm[k][a];
        end
      end
      if (lands) mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_strb);
      if (run && clear_req) begin
        left[k] = dep[k];
        for (int a = 0; a < 32; a++) mm[k][a] = '0;
      end else if (!run)
        left[k]--;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk({nm[k], ".ready"}, rdy[k], left[k] == 0);
      chk({nm[k], ".err"}, er[k], ee[k]);
      chk({nm[k], ".rd_valid"}, rdv[k], ev[k]);
      for (int i = 0; i < 2; i++)
        chk($sformatf("%s.rd_data%0d", nm[k], i), rdd[k][i*32 +: 32], ed[k][i]);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = '0; rd_addr = '0; clear_req = 0;
  endtask

  task automatic randomize_inputs(input int clr_odds);
    wr_en     = $urandom_range(0, 1);
    wr_addr   = 5'($urandom_range(0, 31));
    wr_data   = $urandom;
    wr_strb   = 4'($urandom);
    rd_en     = 2'($urandom);
    for (int i = 0; i < 2; i++)
      rd_addr[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
    clear_req = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
  endtask

  // Asynchronous reset placed between clock edges; outputs must clear immediately.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk({nm[k], ".rst_ready"}, rdy[k], 0);
      chk({nm[k], ".rst_err"}, er[k], 0);
      chk({nm[k], ".rst_valid"}, rdv[k], 0);
      chk({nm[k], ".rst_data"}, rdd[k], 0);
    end
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11;
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    do_reset();

    // sweep: random traffic is ignored, ready rises after exactly 32 edges on A
    for (int c = 0; c < 32; c++) begin
      randomize_inputs(4);
      step();
    end
    idle();
    chk("a.ready_after_sweep", rdy[0], 1);

    // every address reads zero after the sweep
    for (int a = 0; a < 32; a += 2) begin
      rd2(5'(a), 5'(a + 1));
      step();
    end

    // byte-strobed read-modify-write
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_strb = 4'hF; step();
    wr_data = 32'h000000AA; wr_strb = 4'h1; step();
    idle(); rd_en = 2'b01; rd_addr = 10'd5; step();
    chk("a.rmw5", rdd[0][31:0], 32'hDEADBEAA);
    chk("a.rmw5_valid", rdv[0], 2'b01);
    idle(); step();
    chk("a.valid_drop", rdv[0], 2'b00);

    // same-cycle write and read of addr 7 on both ports
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h12345678; wr_strb = 4'hF; rd2(7, 7); step();
    chk("a.bypass_p1", rdd[0][63:32], 32'h12345678);
    chk("b.nobypass_p0", rdd[1][31:0], 32'h0);

    // writes to register 0
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF; step();
    idle(); rd2(0, 0); step();
    chk("a.zero_reg", rdd[0][31:0], 32'h0);
    chk("b.reg0", rdd[1][31:0], 32'hFFFFFFFF);

    // out-of-range on B
    idle(); rd2(25, 25); step();
    chk("b.oor_err", er[1], 1);
    idle(); wr_en = 1; wr_addr = 25; wr_data = 32'hCAFEF00D; wr_strb = 4'hF; step();
    chk("b.oor_wr_err", er[1], 1);
    idle(); rd2(5, 25); step();
    chk("b.alias5", rdd[1][31:0], 32'hDEADBEAA);
    idle(); step();
    chk("b.err_pulse", er[1], 0);

    // randomized traffic with occasional clears
    for (int c = 0; c < 2000; c++) begin
      randomize_inputs(150);
      step();
    end
    idle();
    for (int c = 0; c < 33; c++) step();

    // clear-all from RUN
    wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5; wr_strb = 4'hF; step();
    idle(); clear_req = 1; step();
    idle();
    for (int c = 0; c < 32; c++) step();
    chk("a.ready_after_clear", rdy[0], 1);
    rd2(3, 3); step();
    chk("a.clr3", rdd[0][31:0], 32'h0);

    // reset in the middle of the sweep
    idle(); do_reset();
    for (int c = 0; c < 10; c++) step();
    do_reset();
    for (int c = 0; c < 31; c++) step();
    chk("a.ready_low_31", rdy[0], 0);
    step();
    chk("a.ready_high_32", rdy[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
